// File: rtl/flap_input_controller.sv
// flap_input_controller: synchronises and debounces the flap key, then times a rise/cooldown flap in game ticks.
// Optional macro FLAP_REFLAP_EN: a press during RISE restarts the rise and counts as another flap.
module flap_input_controller #(
   parameter int DB_W            = 16,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int RISE_TICKS      = 8,
   parameter int COOLDOWN_TICKS  = 4
) (
   input  logic       game_clk,
   input  logic       resetn,
   input  logic       key_n,
   input  logic       tick_en,
   input  logic       game_active,
   output logic       user_input_clock,
   output logic       press_pulse,
   output logic [7:0] flap_count
);

   // state    | meaning
   // IDLE     | waiting for an accepted press
   // RISE     | box rising; counts RISE_TICKS game ticks
   // COOLDOWN | presses ignored; counts COOLDOWN_TICKS game ticks

   localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]      RISE_LAST   = 4'(RISE_TICKS - 1);
   localparam logic [3:0]      COOL_LAST   = 4'((COOLDOWN_TICKS == 0) ? 0 : COOLDOWN_TICKS - 1);
   localparam bit              NO_COOLDOWN = (COOLDOWN_TICKS == 0);

   typedef enum logic [1:0] {IDLE, RISE, COOLDOWN} state_t;

   logic            sync_1;
   logic            key_s;
   logic            stable;
   logic [DB_W-1:0] db_cnt;
   state_t          state;
   logic [3:0]      tick_cnt;

   always_ff @(posedge game_clk or negedge resetn) begin
      if (!resetn) begin
         sync_1 <= 1'b1;
         key_s  <= 1'b1;
      end else begin
         sync_1 <= key_n;
         key_s  <= sync_1;
      end
   end

   // press_pulse is registered alongside the accepted level so it appears the cycle stable falls.
   always_ff @(posedge game_clk or negedge resetn) begin
      if (!resetn) begin
         stable      <= 1'b1;
         db_cnt      <= '0;
         press_pulse <= 1'b0;
      end else begin
         press_pulse <= 1'b0;
         if (key_s == stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            stable      <= key_s;
            db_cnt      <= '0;
            press_pulse <= ~key_s;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   always_ff @(posedge game_clk or negedge resetn) begin
      if (!resetn) begin
         state            <= IDLE;
         tick_cnt         <= 4'd0;
         user_input_clock <= 1'b0;
         flap_count       <= 8'd0;
      end else if (!game_active) begin
         state            <= IDLE;
         tick_cnt         <= 4'd0;
         user_input_clock <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (press_pulse) begin
                  state            <= RISE;
                  tick_cnt         <= 4'd0;
                  user_input_clock <= 1'b1;
                  if (flap_count != 8'hFF) flap_count <= flap_count + 8'd1;
               end
            end
            RISE: begin
`ifdef FLAP_REFLAP_EN
               if (press_pulse) begin
                  tick_cnt <= 4'd0;
                  if (flap_count != 8'hFF) flap_count <= flap_count + 8'd1;
               end else
`endif
               if (tick_en) begin
                  if (tick_cnt == RISE_LAST) begin
                     tick_cnt         <= 4'd0;
                     user_input_clock <= 1'b0;
                     state            <= NO_COOLDOWN ? IDLE : COOLDOWN;
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            COOLDOWN: begin
               if (tick_en) begin
                  if (tick_cnt == COOL_LAST) begin
                     state    <= IDLE;
                     tick_cnt <= 4'd0;
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            default: begin
               state            <= IDLE;
               tick_cnt         <= 4'd0;
               user_input_clock <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flap_input_controller.sv
// Bench for flap_input_controller: vector table, directed flap sequences and randomized key/tick traffic
// checked against a tick-budget reference model.
module tb_flap_input_controller;

   localparam int DEB  = 4;
   localparam int RISE = 3;
   localparam int COOL = 2;
`ifdef FLAP_REFLAP_EN
   localparam bit REFLAP = 1'b1;
`else
   localparam bit REFLAP = 1'b0;
`endif

   logic       game_clk;
   logic       resetn;
   logic       key_n;
   logic       tick_en;
   logic       game_active;
   logic       user_input_clock;
   logic       press_pulse;
   logic [7:0] flap_count;

   int checks = 0;
   int errors = 0;

   // reference model: key pipeline, run length of disagreement, and remaining tick budgets
   logic m_sync, m_key_s, m_stable, m_pp;
   int   m_run, rise_left, cool_left, m_cnt;

   typedef struct {
      logic       k;
      logic       t;
      logic       a;
      logic       exp_pp;
      logic       exp_uic;
      logic [7:0] exp_cnt;
   } vec_t;
   vec_t vecs [20];

   flap_input_controller #(
      .DB_W(16), .DEBOUNCE_CYCLES(DEB), .RISE_TICKS(RISE), .COOLDOWN_TICKS(COOL)
   ) dut (
      .game_clk(game_clk), .resetn(resetn), .key_n(key_n), .tick_en(tick_en),
      .game_active(game_active), .user_input_clock(user_input_clock),
      .press_pulse(press_pulse), .flap_count(flap_count)
   );

   initial begin
      game_clk = 1'b0;
      forever #5 game_clk = ~game_clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sync = 1'b1; m_key_s = 1'b1; m_stable = 1'b1; m_pp = 1'b0;
      m_run = 0; rise_left = 0; cool_left = 0; m_cnt = 0;
   endtask

   task automatic model_edge(input logic k, input logic t, input logic a);
      logic pp_old;
      pp_old = m_pp;
      if (!a) begin
         rise_left = 0;
         cool_left = 0;
      end else if (rise_left > 0) begin
         if (REFLAP && pp_old) begin
            rise_left = RISE;
            if (m_cnt < 255) m_cnt++;
         end else if (t) begin
            rise_left--;
            if (rise_left == 0) cool_left = COOL;
         end
      end else if (cool_left > 0) begin
         if (t) cool_left--;
      end else if (pp_old) begin
         rise_left = RISE;
         if (m_cnt < 255) m_cnt++;
      end
      m_pp = 1'b0;
      if (m_key_s != m_stable) begin
         m_run++;
         if (m_run == DEB) begin
            m_stable = m_key_s;
            m_run    = 0;
            m_pp     = ~m_stable;
         end
      end else begin
         m_run = 0;
      end
      m_key_s = m_sync;
      m_sync  = k;
   endtask

   task automatic step(input logic k, input logic t, input logic a);
      key_n = k; tick_en = t; game_active = a;
      @(posedge game_clk);
      model_edge(k, t, a);
      #1;
      check("model_pp", press_pulse, m_pp);
      check("model_uic", user_input_clock, (rise_left > 0) ? 1 : 0);
      check("model_cnt", flap_count, m_cnt);
   endtask

   // asserts reset between edges, so outputs must already be cleared asynchronously
   task automatic do_reset(input logic k);
      #2;
      resetn = 1'b0; key_n = k; tick_en = 1'b0; game_active = 1'b1;
      model_reset();
      #1;
      check("rst_uic", user_input_clock, 0);
      check("rst_pp", press_pulse, 0);
      check("rst_cnt", flap_count, 0);
      @(negedge game_clk);
      @(negedge game_clk);
      resetn = 1'b1;
   endtask

   task automatic press_key(input logic a);
      repeat (DEB + 1) step(1'b0, 1'b0, a);
      step(1'b0, 1'b0, a);
      check("press_pp", press_pulse, 1);
   endtask

   task automatic release_key(input logic a);
      repeat (DEB + 2) step(1'b1, 1'b0, a);
   endtask

   initial begin
      int pulses, pos, cyc;
      resetn = 1'b1; key_n = 1'b1; tick_en = 1'b0; game_active = 1'b1;
      model_reset();

      // key held through reset: press 6 edges after release, rise from edge 7 until the 3rd tick
      for (int i = 0; i < 20; i++)
         vecs[i] = '{1'b0, (i == 8 || i == 13 || i == 18), 1'b1,
                     (i == 5), (i >= 6 && i <= 17), (i >= 6) ? 8'd1 : 8'd0};

      do_reset(1'b0);
      for (int i = 0; i < 20; i++) begin
         step(vecs[i].k, vecs[i].t, vecs[i].a);
         check("tbl_pp", press_pulse, vecs[i].exp_pp);
         check("tbl_uic", user_input_clock, vecs[i].exp_uic);
         check("tbl_cnt", flap_count, vecs[i].exp_cnt);
      end

      // release produces no pulse; bounce then steady low gives one pulse 6 cycles after last fall
      repeat (8) begin
         step(1'b1, 1'b0, 1'b1);
         check("release_pp", press_pulse, 0);
      end
      pulses = 0; pos = -1;
      for (int j = 0; j < 16; j++) begin
         step((j == 3) ? 1'b1 : 1'b0, 1'b0, 1'b1);
         if (press_pulse) begin pulses++; pos = j; end
      end
      check("bounce_count", pulses, 1);
      check("bounce_pos", pos, 9);

      // flap, then press during cooldown is ignored and not queued
      do_reset(1'b1);
      press_key(1'b1);
      release_key(1'b1);
      check("c_rise_uic", user_input_clock, 1);
      check("c_rise_cnt", flap_count, 1);
      step(1'b1, 1'b1, 1'b1); check("c_tick1", user_input_clock, 1);
      step(1'b1, 1'b1, 1'b1); check("c_tick2", user_input_clock, 1);
      step(1'b1, 1'b1, 1'b1); check("c_tick3", user_input_clock, 0);
      press_key(1'b1);
      step(1'b0, 1'b0, 1'b1);
      check("c_cool_uic", user_input_clock, 0);
      check("c_cool_cnt", flap_count, 1);
      release_key(1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0, 1'b1);
      check("c_not_queued", user_input_clock, 0);
      check("c_not_queued_cnt", flap_count, 1);
      press_key(1'b1);
      step(1'b1, 1'b0, 1'b1);
      check("c_after_cool_uic", user_input_clock, 1);
      check("c_after_cool_cnt", flap_count, 2);

      // game_active dropped mid-rise, then a press while inactive
      step(1'b1, 1'b0, 1'b0);
      check("d_drop_uic", user_input_clock, 0);
      release_key(1'b0);
      press_key(1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("d_inactive_cnt", flap_count, 2);
      repeat (3) step(1'b1, 1'b0, 1'b1);
      check("d_ignored_uic", user_input_clock, 0);
      check("d_ignored_cnt", flap_count, 2);

      // press after the 2nd rise tick
      do_reset(1'b1);
      press_key(1'b1);
      release_key(1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      press_key(1'b1);
      step(1'b1, 1'b0, 1'b1);
      check("e_before", user_input_clock, 1);
      step(1'b1, 1'b1, 1'b1); check("e_tick3", user_input_clock, REFLAP ? 1 : 0);
      step(1'b1, 1'b1, 1'b1); check("e_tick4", user_input_clock, REFLAP ? 1 : 0);
      step(1'b1, 1'b1, 1'b1); check("e_tick5", user_input_clock, 0);
      check("e_cnt", flap_count, REFLAP ? 2 : 1);

      // reset mid-flap clears the output before the next edge
      do_reset(1'b1);
      press_key(1'b1);
      step(1'b1, 1'b0, 1'b1);
      check("f_pre_uic", user_input_clock, 1);
      do_reset(1'b1);
      repeat (4) step(1'b1, 1'b1, 1'b1);
      check("f_post_cnt", flap_count, 0);

      // saturation of the flap counter
      repeat (265) begin
         repeat (DEB + 2) step(1'b0, 1'b1, 1'b1);
         repeat (DEB + 2) step(1'b1, 1'b1, 1'b1);
      end
      check("sat_cnt", flap_count, 255);

      // randomized key bursts, ticks and game_active drops
      do_reset(1'b1);
      cyc = 0;
      while (cyc < 3000) begin
         int   hold;
         logic k, a_burst;
         hold    = $urandom_range(1, 12);
         k       = 1'($urandom_range(0, 1));
         a_burst = ($urandom_range(0, 7) != 0);
         for (int n = 0; n < hold; n++) begin
            step(k, ($urandom_range(0, 3) == 0), a_burst && ($urandom_range(0, 31) != 0));
            cyc++;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
